i2c_cfg_seq: RTL and testbench
==============================

Name: i2c_cfg_seq

Overview:
- Sequences a table of I2C register operations into i2c_ctrl to configure a camera sensor or other 16-bit-addressed device after power-up.
- Fetches entries from an external combinational table through cfg_index/cfg_data.
- Issues write, read-verify and delay operations, with timeout recovery and bounded retries.
- Reports busy, done and error status to the system.

Parameters:
CFG_NUM, 10'd256, number of table entries (indices 0..CFG_NUM-1)
IDX_W, 10, width of cfg_index
INIT_DELAY_CYC, 24'd1_000_000, sys_clk cycles to wait after reset before the first entry
MS_CYC, 16'd50_000, sys_clk cycles per delay unit (1 ms at 50 MHz)
TIMEOUT_CYC, 24'd500_000, maximum sys_clk cycles from i2c_start to i2c_end
MAX_RETRY, 2'd3, retries per entry before error
ADDR16, 1'b1, value driven on addr_num

Ports:
sys_clk  in  1  system clock, same clock that generates i2c_clk
sys_rst_n  in  1  asynchronous active-low reset
cfg_start  in  1  one-cycle pulse; re-runs the table (honoured only in DONE or ERROR)
i2c_clk  in  1  i2c_ctrl drive clock, registered from sys_clk
i2c_end  in  1  i2c_ctrl completion, high for one i2c_clk period
i2c_rd_data  in  8  i2c_ctrl read data
cfg_data  in  26  table entry: [25:24] op, [23:8] addr, [7:0] data
cfg_index  out  IDX_W  table address
i2c_start  out  1  i2c_ctrl trigger
wr_en  out  1  i2c_ctrl write enable
rd_en  out  1  i2c_ctrl read enable
addr_num  out  1  constant ADDR16
byte_addr  out  16  register address
wr_data  out  8  write data / expected read value
i2c_rst_n  out  1  active-low recovery reset for i2c_ctrl (ANDed with sys_rst_n at top level)
cfg_busy  out  1  sequence in progress
cfg_done  out  1  table completed successfully (level)
cfg_err  out  1  table aborted (level)
err_index  out  IDX_W  index of the failing entry

Behaviour:
- Reset: sys_rst_n is asynchronous, active-low; clock is sys_clk. During reset all outputs are 0, except i2c_rst_n=1 and addr_num=ADDR16. State goes to PWR_WAIT.
- Opcodes:
  - 00 WRITE: write data to addr.
  - 01 VERIFY: read addr, compare to data.
  - 10 DELAY: wait cfg_data[15:0]*MS_CYC cycles.
  - 11 END: stop the table early.
- i2c_clk and i2c_end are synchronous to sys_clk. Edge-detect each with one delay register; no synchronizer.
- States:
  - PWR_WAIT: count INIT_DELAY_CYC, then -> FETCH with cfg_index=0 and cfg_busy=1.
  - FETCH: one cycle for the table lookup. cfg_data is sampled on the next edge into LATCH.
  - LATCH:
    - Register byte_addr and wr_data.
    - WRITE -> ISSUE with wr_en=1, rd_en=0.
    - VERIFY -> ISSUE with wr_en=0, rd_en=1.
    - DELAY -> DELAY.
    - END -> DONE.
  - ISSUE: assert i2c_start until two i2c_clk rising edges are seen, then drop it -> WAIT_END. The timeout counter starts on entry to ISSUE.
  - WAIT_END:
    - Rising edge of i2c_end -> CHECK.
    - Timeout counter reaching TIMEOUT_CYC-1 -> RECOVER.
  - CHECK:
    - WRITE -> NEXT.
    - VERIFY with i2c_rd_data==wr_data -> NEXT.
    - VERIFY mismatch -> RETRY.
  - RECOVER: drive i2c_rst_n=0 for 16 cycles, then -> RETRY.
  - RETRY:
    - retry_cnt<MAX_RETRY: increment it -> ISSUE.
    - Otherwise: err_index=cfg_index -> ERROR.
  - DELAY: count the requested cycles -> NEXT. A delay field of 0 takes 1 cycle.
  - NEXT:
    - Clear retry_cnt.
    - cfg_index==CFG_NUM-1 -> DONE.
    - Otherwise increment cfg_index -> FETCH.
  - DONE: cfg_done=1, cfg_busy=0, cfg_index holds.
  - ERROR: cfg_err=1, cfg_busy=0.
- cfg_start in DONE/ERROR:
  - Clears done, err, err_index and retry_cnt.
  - Sets cfg_index=0 -> FETCH; the power-up wait is not repeated.
  - cfg_start is ignored in any other state.
- byte_addr, wr_data, wr_en and rd_en are stable from ISSUE entry through CHECK. wr_en and rd_en are never both 1; both are 0 outside ISSUE/WAIT_END/CHECK.
- i2c_start is never asserted while i2c_rst_n=0.
- An i2c_end edge arriving in any state other than WAIT_END is ignored.
- An i2c_end edge and a timeout on the same cycle: i2c_end wins.
- Asynchronous reset mid-transfer aborts immediately and restarts the full power-up sequence.
- Counters saturate/compare with widths wide enough for their parameters. The delay product is computed as 16x16 -> 32 bits.

Test Plan:
- Params: INIT_DELAY_CYC=100, MS_CYC=10, CFG_NUM=4, TIMEOUT_CYC=5000. Table = WRITE 0x3008/0x82, WRITE 0x3103/0x03, DELAY 5, WRITE 0x4300/0x6F. Required: 3 i2c_start bursts with matching byte_addr/wr_data, and a 50-cycle gap after entry 1. cfg_done=1 follows the last i2c_end edge; cfg_index=3.
- First entry is END: after 100 wait cycles, cfg_done=1; no i2c_start is ever asserted.
- VERIFY 0x300A/0x56, model returns 0x56: entry passes with rd_en=1, wr_en=0. Model returns 0x55 for all attempts: 4 transfers (1+MAX_RETRY), then cfg_err=1 with err_index=0.
- Model never returns i2c_end: i2c_rst_n low 16 cycles after each 5000-cycle timeout, 4 attempts total, then cfg_err=1.
- Timeout on the first attempt, success on the second: sequence continues, retry_cnt is cleared for the next entry, and cfg_done=1.
- cfg_start pulsed while busy is ignored. Pulsed in DONE: table reruns from index 0 without the 100-cycle wait. Reset asserted during WAIT_END: all outputs go to reset values immediately.

Source files
------------

// File: rtl/i2c_cfg_seq_if.sv
// Bundle between the configuration sequencer, the i2c_ctrl engine, the entry table and the system.
// The master side is the sequencer. The slave side is the controller, table and status consumer.
interface i2c_cfg_seq_if #(
    parameter int IDX_W = 10
);
    logic             cfg_start;
    logic             i2c_clk;
    logic             i2c_end;
    logic [7:0]       i2c_rd_data;
    logic [25:0]      cfg_data;
    logic [IDX_W-1:0] cfg_index;
    logic             i2c_start;
    logic             wr_en;
    logic             rd_en;
    logic             addr_num;
    logic [15:0]      byte_addr;
    logic [7:0]       wr_data;
    logic             i2c_rst_n;
    logic             cfg_busy;
    logic             cfg_done;
    logic             cfg_err;
    logic [IDX_W-1:0] err_index;

    modport master (
        input  cfg_start, i2c_clk, i2c_end, i2c_rd_data, cfg_data,
        output cfg_index, i2c_start, wr_en, rd_en, addr_num, byte_addr, wr_data,
               i2c_rst_n, cfg_busy, cfg_done, cfg_err, err_index
    );

    modport slave (
        output cfg_start, i2c_clk, i2c_end, i2c_rd_data, cfg_data,
        input  cfg_index, i2c_start, wr_en, rd_en, addr_num, byte_addr, wr_data,
               i2c_rst_n, cfg_busy, cfg_done, cfg_err, err_index
    );
endinterface

// File: rtl/i2c_cfg_seq.sv
// Power-up I2C configuration sequencer: walks a write/verify/delay/end table into i2c_ctrl
// with per-transfer timeout, controller recovery reset and bounded retries.
//
// state    | meaning
// PWR_WAIT | post-reset settling wait
// FETCH    | table lookup at cfg_index
// LATCH    | decode the fetched entry
// ISSUE    | i2c_start held for two i2c_clk rising edges
// WAIT_END | waiting for i2c_end or timeout
// CHECK    | judge the completed transfer
// RECOVER  | i2c_rst_n held low for 16 cycles
// RETRY    | retry the entry or give up
// DELAY    | table-requested wait
// NEXT     | advance to the next entry
// DONE     | table completed
// ERROR    | table aborted
module i2c_cfg_seq #(
    parameter logic [9:0]  CFG_NUM        = 10'd256,
    parameter int          IDX_W          = 10,
    parameter logic [23:0] INIT_DELAY_CYC = 24'd1_000_000,
    parameter logic [15:0] MS_CYC         = 16'd50_000,
    parameter logic [23:0] TIMEOUT_CYC    = 24'd500_000,
    parameter logic [1:0]  MAX_RETRY      = 2'd3,
    parameter logic        ADDR16         = 1'b1
) (
    input  logic          sys_clk,
    input  logic          sys_rst_n,
    i2c_cfg_seq_if.master bus
);

    typedef enum logic [3:0] {
        S_PWR_WAIT, S_FETCH, S_LATCH, S_ISSUE, S_WAIT_END, S_CHECK,
        S_RECOVER, S_RETRY, S_DELAY, S_NEXT, S_DONE, S_ERROR
    } state_t;

    localparam logic [1:0] OP_WRITE  = 2'b00;
    localparam logic [1:0] OP_VERIFY = 2'b01;
    localparam logic [1:0] OP_DELAY  = 2'b10;

    // Timer reload values are "cycles - 1" so the terminal count at zero ends the interval.
    localparam logic [31:0] INIT_LD = (INIT_DELAY_CYC == 24'd0) ? 32'd0 : 32'(INIT_DELAY_CYC) - 32'd1;
    localparam logic [31:0] TMO_LD  = (TIMEOUT_CYC == 24'd0) ? 32'd0 : 32'(TIMEOUT_CYC) - 32'd1;
    localparam logic [31:0] RCV_LD  = 32'd15;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CFG_NUM - 10'd1);

    state_t           state, state_nx;
    logic [31:0]      tmr;
    logic [25:0]      ent;
    logic [15:0]      addr_q;
    logic [7:0]       data_q;
    logic [IDX_W-1:0] idx, err_idx;
    logic [1:0]       retry;
    logic [1:0]       clk_cnt;
    logic             clk_d, end_d, rst_q;
    logic             clk_rise, end_rise, tmr_zero, xfer;
    logic [31:0]      dly_prod, dly_ld;

    assign clk_rise = bus.i2c_clk & ~clk_d;
    assign end_rise = bus.i2c_end & ~end_d;
    assign tmr_zero = (tmr == 32'd0);
    assign dly_prod = {16'd0, ent[15:0]} * {16'd0, MS_CYC};
    assign dly_ld   = (dly_prod == 32'd0) ? 32'd0 : dly_prod - 32'd1;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state <= S_PWR_WAIT;
        else            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_PWR_WAIT: if (tmr_zero) state_nx = S_FETCH;
            S_FETCH:    state_nx = S_LATCH;
            S_LATCH: begin
                case (ent[25:24])
                    OP_WRITE, OP_VERIFY: state_nx = S_ISSUE;
                    OP_DELAY:            state_nx = S_DELAY;
                    default:             state_nx = S_DONE;
                endcase
            end
            // A dead controller clock would otherwise stall ISSUE forever, so the timeout covers it too.
            S_ISSUE: begin
                if (clk_rise && clk_cnt == 2'd1) state_nx = S_WAIT_END;
                else if (tmr_zero)               state_nx = S_RECOVER;
            end
            S_WAIT_END: begin
                if (end_rise)      state_nx = S_CHECK;
                else if (tmr_zero) state_nx = S_RECOVER;
            end
            S_CHECK: begin
                if (ent[25:24] == OP_VERIFY && bus.i2c_rd_data != data_q) state_nx = S_RETRY;
                else                                                    state_nx = S_NEXT;
            end
            S_RECOVER: if (tmr_zero) state_nx = S_RETRY;
            S_RETRY:   state_nx = (retry < MAX_RETRY) ? S_ISSUE : S_ERROR;
            S_DELAY:   if (tmr_zero) state_nx = S_NEXT;
            S_NEXT:    state_nx = (idx == LAST_IDX) ? S_DONE : S_FETCH;
            S_DONE, S_ERROR: if (bus.cfg_start) state_nx = S_FETCH;
            default:   state_nx = S_PWR_WAIT;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            tmr     <= INIT_LD;
            ent     <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            idx     <= '0;
            err_idx <= '0;
            retry   <= '0;
            clk_cnt <= '0;
            clk_d   <= 1'b0;
            end_d   <= 1'b0;
            rst_q   <= 1'b1;
        end else begin
            clk_d <= bus.i2c_clk;
            end_d <= bus.i2c_end;
            // Registered so the controller reset line never glitches on state decode.
            rst_q <= (state_nx != S_RECOVER);

            if (state != S_ISSUE) clk_cnt <= '0;
            else if (clk_rise)    clk_cnt <= clk_cnt + 2'd1;

            if (state_nx == S_ISSUE && state != S_ISSUE)          tmr <= TMO_LD;
            else if (state_nx == S_RECOVER && state != S_RECOVER) tmr <= RCV_LD;
            else if (state_nx == S_DELAY && state != S_DELAY)     tmr <= dly_ld;
            else if (!tmr_zero)                                   tmr <= tmr - 32'd1;

            if (state == S_FETCH) ent <= bus.cfg_data;
            if (state == S_LATCH) begin
                addr_q <= ent[23:8];
                data_q <= ent[7:0];
            end

            case (state)
                S_NEXT: begin
                    retry <= '0;
                    if (state_nx == S_FETCH) idx <= idx + IDX_W'(1);
                end
                S_RETRY: begin
                    if (state_nx == S_ISSUE) retry   <= retry + 2'd1;
                    else                     err_idx <= idx;
                end
                S_DONE, S_ERROR: begin
                    if (bus.cfg_start) begin
                        idx     <= '0;
                        err_idx <= '0;
                        retry   <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        xfer          = (state == S_ISSUE) || (state == S_WAIT_END) || (state == S_CHECK);
        bus.i2c_start = (state == S_ISSUE);
        bus.wr_en     = xfer && (ent[25:24] == OP_WRITE);
        bus.rd_en     = xfer && (ent[25:24] == OP_VERIFY);
        bus.cfg_busy  = !((state == S_PWR_WAIT) || (state == S_DONE) || (state == S_ERROR));
        bus.cfg_done  = (state == S_DONE);
        bus.cfg_err   = (state == S_ERROR);
    end

    assign bus.addr_num  = ADDR16;
    assign bus.byte_addr = addr_q;
    assign bus.wr_data   = data_q;
    assign bus.cfg_index = idx;
    assign bus.err_index = err_idx;
    assign bus.i2c_rst_n = rst_q;

endmodule

// File: tb/tb_i2c_cfg_seq.sv
// Directed bench for i2c_cfg_seq with a small i2c_ctrl responder and a combinational entry table.
module tb_i2c_cfg_seq;
    localparam int IDX_W = 10;

    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b0;

    i2c_cfg_seq_if #(.IDX_W(IDX_W)) bus ();

    i2c_cfg_seq #(
        .CFG_NUM(10'd4), .IDX_W(IDX_W), .INIT_DELAY_CYC(24'd100), .MS_CYC(16'd10),
        .TIMEOUT_CYC(24'd5000), .MAX_RETRY(2'd3), .ADDR16(1'b1)
    ) dut (
        .sys_clk(sys_clk),
        .sys_rst_n(sys_rst_n),
        .bus(bus)
    );

    always #5 sys_clk = ~sys_clk;

    logic [25:0] tbl [4];
    logic [7:0]  rd_val;
    logic [7:0]  drop_mask;
    int          tx_base;
    assign bus.cfg_data    = tbl[bus.cfg_index[1:0]];
    assign bus.i2c_rd_data = rd_val;

    // i2c_clk runs at sys_clk/4
    logic [1:0] div = 2'd0;
    always @(negedge sys_clk) begin
        div = div + 2'd1;
        bus.i2c_clk = div[1];
    end

    // Responder: i2c_end rises 20 cycles after an i2c_start edge, held 4 cycles, unless dropped.
    int   tx_n = 0, m_cnt = 0, m_hold = 0, m_k;
    logic m_sd = 1'b0;
    always @(negedge sys_clk) begin
        if (!sys_rst_n || bus.i2c_rst_n === 1'b0) begin
            m_cnt = 0; m_hold = 0; m_sd = 1'b0; bus.i2c_end = 1'b0;
        end else begin
            if (bus.i2c_start === 1'b1 && !m_sd) begin
                m_k = tx_n - tx_base;
                if (!(m_k >= 0 && m_k < 8 && drop_mask[m_k[2:0]])) m_cnt = 20;
                tx_n++;
            end
            m_sd = (bus.i2c_start === 1'b1);
            if (m_hold != 0) m_hold--;
            if (m_cnt != 0) begin
                m_cnt--;
                if (m_cnt == 0) m_hold = 4;
            end
            bus.i2c_end = (m_hold != 0);
        end
    end

    logic [15:0] a_log [32];
    logic [7:0]  d_log [32];
    logic        w_log [32];
    logic        r_log [32];
    int          s_cyc [32];
    int          f_cyc [32];
    int   cyc = 0, start_cnt = 0, end_cnt = 0, low_runs = 0, low_cur = 0, low_last = 0, viol = 0;
    logic mon_sd = 1'b0, mon_ed = 1'b0, mon_rh = 1'b1;
    always @(negedge sys_clk) begin
        cyc++;
        if (bus.i2c_start === 1'b1 && !mon_sd) begin
            a_log[start_cnt % 32] = bus.byte_addr;
            d_log[start_cnt % 32] = bus.wr_data;
            w_log[start_cnt % 32] = bus.wr_en;
            r_log[start_cnt % 32] = bus.rd_en;
            s_cyc[start_cnt % 32] = cyc;
            start_cnt++;
        end
        mon_sd = (bus.i2c_start === 1'b1);
        if (bus.i2c_end === 1'b1 && !mon_ed) end_cnt++;
        mon_ed = (bus.i2c_end === 1'b1);
        if (bus.i2c_rst_n === 1'b0) begin
            if (mon_rh) begin
                f_cyc[low_runs % 32] = cyc;
                low_runs++;
            end
            low_cur++;
        end else if (!mon_rh) begin
            low_last = low_cur;
            low_cur  = 0;
        end
        mon_rh = (bus.i2c_rst_n !== 1'b0);
        if (bus.i2c_start === 1'b1 && bus.i2c_rst_n === 1'b0) viol++;
        if (bus.wr_en === 1'b1 && bus.rd_en === 1'b1) viol++;
    end

    int n_tests = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic hold_reset();
        @(negedge sys_clk);
        sys_rst_n = 1'b0;
        repeat (3) @(negedge sys_clk);
    endtask

    task automatic release_reset(output int n);
        sys_rst_n = 1'b1;
        n = 0;
        do begin
            @(negedge sys_clk);
            n++;
        end while (!bus.cfg_busy && !bus.cfg_done && n < 1000);
    endtask

    task automatic wait_fin(input string tag, input int budget, output int n);
        n = 0;
        do begin
            @(negedge sys_clk);
            n++;
        end while (!bus.cfg_done && !bus.cfg_err && n < budget);
        chk(tag, 32'(n < budget), 32'd1);
    endtask

    function automatic logic [25:0] ent(input logic [1:0] op, input logic [15:0] a, input logic [7:0] d);
        return {op, a, d};
    endfunction

    int n, sb, eb, lb, diff;

    initial begin
        bus.cfg_start = 1'b0;
        rd_val    = 8'h00;
        drop_mask = 8'h00;
        tx_base   = 0;
        tbl[0] = ent(2'b00, 16'h3008, 8'h82);
        tbl[1] = ent(2'b00, 16'h3103, 8'h03);
        tbl[2] = {2'b10, 24'h000005};
        tbl[3] = ent(2'b00, 16'h4300, 8'h6F);

        // Reset values
        repeat (3) @(negedge sys_clk);
        chk("rst_start",    bus.i2c_start, 0);
        chk("rst_en",       {bus.wr_en, bus.rd_en}, 0);
        chk("rst_addr_num", bus.addr_num, 1);
        chk("rst_addr",     bus.byte_addr, 0);
        chk("rst_data",     bus.wr_data, 0);
        chk("rst_i2c_rst",  bus.i2c_rst_n, 1);
        chk("rst_status",   {bus.cfg_busy, bus.cfg_done, bus.cfg_err}, 0);
        chk("rst_index",    {bus.cfg_index, bus.err_index}, 0);

        // Write / delay / write table
        sb = start_cnt; eb = end_cnt;
        release_reset(n);
        chk("t1_pwr_wait", n, 100);
        wait_fin("t1_wait", 3000, n);
        chk("t1_done",   {bus.cfg_done, bus.cfg_err, bus.cfg_busy}, 3'b100);
        chk("t1_index",  bus.cfg_index, 3);
        chk("t1_starts", start_cnt - sb, 3);
        chk("t1_ends",   end_cnt - eb, 3);
        chk("t1_e0",     {a_log[sb], d_log[sb], w_log[sb], r_log[sb]}, {16'h3008, 8'h82, 2'b10});
        chk("t1_e1",     {a_log[sb+1], d_log[sb+1], w_log[sb+1], r_log[sb+1]}, {16'h3103, 8'h03, 2'b10});
        chk("t1_e3",     {a_log[sb+2], d_log[sb+2], w_log[sb+2], r_log[sb+2]}, {16'h4300, 8'h6F, 2'b10});
        diff = (s_cyc[sb+2] - s_cyc[sb+1]) - (s_cyc[sb+1] - s_cyc[sb]);
        chk("t1_delay_gap", diff, 53);

        // Rerun from DONE without the power-up wait; cfg_start while busy is ignored
        sb = start_cnt;
        bus.cfg_start = 1'b1;
        @(negedge sys_clk);
        bus.cfg_start = 1'b0;
        chk("rerun_busy",  {bus.cfg_busy, bus.cfg_done}, 2'b10);
        chk("rerun_index", bus.cfg_index, 0);
        n = 0;
        while (bus.cfg_index != 2 && n < 2000) begin
            @(negedge sys_clk);
            n++;
        end
        chk("rerun_reach_idx2", 32'(n < 2000), 1);
        bus.cfg_start = 1'b1;
        @(negedge sys_clk);
        bus.cfg_start = 1'b0;
        chk("busy_start_ignored", {bus.cfg_busy, 8'(bus.cfg_index)}, {1'b1, 8'd2});
        wait_fin("rerun_wait", 3000, n);
        chk("rerun_starts", start_cnt - sb, 3);
        chk("rerun_done",   {bus.cfg_done, 8'(bus.cfg_index)}, {1'b1, 8'd3});

        // First entry END
        hold_reset();
        tbl[0] = {2'b11, 24'h0};
        sb = start_cnt;
        release_reset(n);
        wait_fin("t2_wait", 500, eb);
        chk("t2_cycles", n + eb, 102);
        chk("t2_done",   {bus.cfg_done, bus.cfg_err}, 2'b10);
        chk("t2_starts", start_cnt - sb, 0);

        // VERIFY match
        hold_reset();
        tbl[0] = ent(2'b01, 16'h300A, 8'h56);
        tbl[1] = {2'b11, 24'h0};
        rd_val = 8'h56;
        sb = start_cnt;
        release_reset(n);
        wait_fin("t3_wait", 3000, n);
        chk("t3_done",   {bus.cfg_done, bus.cfg_err}, 2'b10);
        chk("t3_starts", start_cnt - sb, 1);
        chk("t3_xfer",   {a_log[sb], d_log[sb], w_log[sb], r_log[sb]}, {16'h300A, 8'h56, 2'b01});

        // VERIFY mismatch on entry 1: 1 + MAX_RETRY attempts then error
        hold_reset();
        tbl[0] = ent(2'b00, 16'h1234, 8'hAA);
        tbl[1] = ent(2'b01, 16'h300A, 8'h56);
        tbl[2] = {2'b11, 24'h0};
        rd_val = 8'h55;
        sb = start_cnt;
        release_reset(n);
        wait_fin("t4_wait", 3000, n);
        chk("t4_err",       {bus.cfg_done, bus.cfg_err, bus.cfg_busy}, 3'b010);
        chk("t4_err_index", bus.err_index, 1);
        chk("t4_starts",    start_cnt - sb, 5);
        chk("t4_last",      {a_log[sb+4], w_log[sb+4], r_log[sb+4]}, {16'h300A, 2'b01});

        // cfg_start in ERROR clears status and reruns
        rd_val = 8'h56;
        bus.cfg_start = 1'b1;
        @(negedge sys_clk);
        bus.cfg_start = 1'b0;
        chk("t4_clear", {bus.cfg_err, bus.cfg_busy, 8'(bus.err_index), 8'(bus.cfg_index)}, {2'b01, 16'h0});
        wait_fin("t4_rerun_wait", 3000, n);
        chk("t4_rerun_done", {bus.cfg_done, bus.cfg_err}, 2'b10);

        // No i2c_end ever: timeout, recovery reset, retries, error
        hold_reset();
        tbl[0] = ent(2'b00, 16'h3008, 8'h82);
        tbl[1] = {2'b11, 24'h0};
        drop_mask = 8'hFF;
        tx_base = tx_n;
        sb = start_cnt; lb = low_runs;
        release_reset(n);
        wait_fin("t5_wait", 30000, n);
        chk("t5_err",        {bus.cfg_done, bus.cfg_err}, 2'b01);
        chk("t5_err_index",  bus.err_index, 0);
        chk("t5_starts",     start_cnt - sb, 4);
        chk("t5_recovers",   low_runs - lb, 4);
        chk("t5_rst_len",    low_last, 16);
        chk("t5_timeout",    f_cyc[lb] - s_cyc[sb], 5000);

        // Timeout then success on entry 0; entry 1 needs all retries (retry count must restart)
        hold_reset();
        tbl[0] = ent(2'b00, 16'h3008, 8'h82);
        tbl[1] = ent(2'b00, 16'h3103, 8'h03);
        tbl[2] = ent(2'b00, 16'h3200, 8'h11);
        tbl[3] = ent(2'b00, 16'h4300, 8'h6F);
        drop_mask = 8'b0001_1101;
        tx_base = tx_n;
        sb = start_cnt; lb = low_runs;
        release_reset(n);
        wait_fin("t6_wait", 40000, n);
        chk("t6_done",     {bus.cfg_done, bus.cfg_err}, 2'b10);
        chk("t6_index",    bus.cfg_index, 3);
        chk("t6_starts",   start_cnt - sb, 8);
        chk("t6_recovers", low_runs - lb, 4);
        chk("t6_last",     {a_log[sb+7], d_log[sb+7]}, {16'h4300, 8'h6F});

        // Asynchronous reset while waiting for i2c_end
        hold_reset();
        tbl[0] = ent(2'b00, 16'h3008, 8'h82);
        drop_mask = 8'hFF;
        tx_base = tx_n;
        sb = start_cnt;
        release_reset(n);
        n = 0;
        while (start_cnt == sb && n < 1000) begin
            @(negedge sys_clk);
            n++;
        end
        repeat (30) @(negedge sys_clk);
        chk("t7_in_wait_end", {bus.i2c_start, bus.wr_en, bus.cfg_busy}, 3'b011);
        #2 sys_rst_n = 1'b0;
        #1;
        chk("t7_rst_ctrl",   {bus.i2c_start, bus.wr_en, bus.rd_en, bus.i2c_rst_n, bus.addr_num}, 5'b00011);
        chk("t7_rst_bus",    {bus.byte_addr, bus.wr_data}, 24'h0);
        chk("t7_rst_status", {bus.cfg_busy, bus.cfg_done, bus.cfg_err}, 3'b000);
        @(negedge sys_clk);
        release_reset(n);
        chk("t7_pwr_wait", n, 100);

        chk("no_violations", viol, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
